line_clear_sequencer: RTL and testbench

- Sequences the lock-to-spawn step of a piece drop: commits the locked piece into the field, runs the row clearer, accounts score/lines/level, then requests the next piece.
- Sits between the game-control FSM and the field datapath; sole owner of the row clearer's enable.
- One piece event in flight at a time; further lock requests are ignored while busy.

---
 rtl/line_clear_sequencer_pkg.sv | 15 +
 rtl/line_clear_sequencer_if.sv | 26 ++
 rtl/line_clear_sequencer_score_accumulator.sv | 53 +++++
 rtl/line_clear_sequencer.sv | 81 ++++++++
 tb/tb_line_clear_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/line_clear_sequencer_pkg.sv
// line_clear_sequencer_pkg: shared scoring constants, base-points table and sequencer state encoding
package line_clear_sequencer_pkg;
    localparam int SCORE_MAX       = 999999;
    localparam int LINES_PER_LEVEL = 10;
    localparam int LEVEL_MAX       = 15;

    typedef enum logic [2:0] {IDLE, MERGE, CLEAN, SCORE, SPAWN, OVER} seq_state_t;

    function automatic logic [10:0] base_pts(input logic [2:0] lines);
        return lines == 3'd1 ? 11'd40  :
               lines == 3'd2 ? 11'd100 :
               lines == 3'd3 ? 11'd300 :
               lines == 3'd4 ? 11'd1200 : 11'd0;
    endfunction
endpackage

// File: rtl/line_clear_sequencer_if.sv
// line_clear_sequencer_if: game-control/field handshakes and score outputs of the line-clear sequencer
interface line_clear_sequencer_if;
    logic        lock_req;
    logic        merge_we;
    logic        clean_en;
    logic        clean_done;
    logic [2:0]  clean_lines;
    logic        spawn_req;
    logic        spawn_ack;
    logic        spawn_blocked;
    logic        busy;
    logic [19:0] score;
    logic [15:0] total_lines;
    logic [3:0]  level;
    logic        game_over;
    logic        err_timeout;

    modport master (
        output lock_req, clean_done, clean_lines, spawn_ack, spawn_blocked,
        input  merge_we, clean_en, spawn_req, busy, score, total_lines, level, game_over, err_timeout
    );
    modport slave (
        input  lock_req, clean_done, clean_lines, spawn_ack, spawn_blocked,
        output merge_we, clean_en, spawn_req, busy, score, total_lines, level, game_over, err_timeout
    );
endinterface

// File: rtl/line_clear_sequencer_score_accumulator.sv
// line_clear_sequencer_score_accumulator: saturating score, line total and level progression per strobe
module line_clear_sequencer_score_accumulator
    import line_clear_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_i,
    input  logic [2:0]  lines_i,
    output logic [19:0] score_o,
    output logic [15:0] total_lines_o,
    output logic [3:0]  level_o
);
    logic [19:0] score_q, score_d;
    logic [15:0] total_q, total_d;
    logic [3:0]  level_q, level_d;
    logic [3:0]  prog_q, prog_d;
    logic [15:0] incr;
    logic [20:0] score_sum;
    logic [16:0] total_sum;
    logic [3:0]  prog_sum;
    logic        step;

    // incr uses the level held before this update
    always_comb begin
        incr      = 16'(base_pts(lines_i)) * 16'({1'b0, level_q} + 5'd1);
        score_sum = {1'b0, score_q} + 21'(incr);
        total_sum = {1'b0, total_q} + 17'(lines_i);
        prog_sum  = prog_q + 4'(lines_i);
        step      = prog_sum >= 4'(LINES_PER_LEVEL);
        score_d   = score_sum > 21'(SCORE_MAX) ? 20'(SCORE_MAX) : score_sum[19:0];
        total_d   = total_sum[16] ? 16'hFFFF : total_sum[15:0];
        prog_d    = step ? prog_sum - 4'(LINES_PER_LEVEL) : prog_sum;
        level_d   = step && level_q != 4'(LEVEL_MAX) ? level_q + 4'd1 : level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= '0;
            total_q <= '0;
            level_q <= '0;
            prog_q  <= '0;
        end else if (upd_i) begin
            score_q <= score_d;
            total_q <= total_d;
            level_q <= level_d;
            prog_q  <= prog_d;
        end
    end

    assign score_o       = score_q;
    assign total_lines_o = total_q;
    assign level_o       = level_q;
endmodule

// File: rtl/line_clear_sequencer.sv
// line_clear_sequencer: lock -> merge -> row clear -> score -> spawn sequencing for one piece at a time
module line_clear_sequencer
    import line_clear_sequencer_pkg::*;
#(
    parameter int CLEAN_TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    line_clear_sequencer_if.slave  bus
);
    seq_state_t  state_q;
    logic        merge_we_q, clean_en_q, spawn_req_q, game_over_q, err_timeout_q;
    logic [15:0] timer_q;
    logic [2:0]  lines_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            merge_we_q    <= 1'b0;
            clean_en_q    <= 1'b0;
            spawn_req_q   <= 1'b0;
            game_over_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            timer_q       <= '0;
            lines_q       <= '0;
        end else begin
            merge_we_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.lock_req) begin
                    state_q    <= MERGE;
                    merge_we_q <= 1'b1;
                end
                MERGE: begin
                    state_q    <= CLEAN;
                    clean_en_q <= 1'b1;
                    timer_q    <= '0;
                end
                CLEAN: begin
                    timer_q <= timer_q + 16'd1;
                    if (bus.clean_done) begin
                        lines_q    <= bus.clean_lines > 3'd4 ? 3'd4 : bus.clean_lines;
                        clean_en_q <= 1'b0;
                        state_q    <= SCORE;
                    end else if (timer_q == 16'(CLEAN_TIMEOUT - 1)) begin
                        err_timeout_q <= 1'b1;
                        lines_q       <= '0;
                        clean_en_q    <= 1'b0;
                        state_q       <= SCORE;
                    end
                end
                SCORE: begin
                    state_q     <= SPAWN;
                    spawn_req_q <= 1'b1;
                end
                SPAWN: if (bus.spawn_ack) begin
                    spawn_req_q <= 1'b0;
                    game_over_q <= bus.spawn_blocked;
                    state_q     <= bus.spawn_blocked ? OVER : IDLE;
                end
                default: ;
            endcase
        end
    end

    line_clear_sequencer_score_accumulator u_acc (
        .clk           (clk),
        .rst           (rst),
        .upd_i         (state_q == SCORE),
        .lines_i       (lines_q),
        .score_o       (bus.score),
        .total_lines_o (bus.total_lines),
        .level_o       (bus.level)
    );

    assign bus.merge_we    = merge_we_q;
    assign bus.clean_en    = clean_en_q;
    assign bus.spawn_req   = spawn_req_q;
    assign bus.game_over   = game_over_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.busy        = !(state_q inside {IDLE, OVER});
endmodule

// File: tb/tb_line_clear_sequencer.sv
// tb_line_clear_sequencer: directed vector table plus timeout, saturation, game-over and reset sequences
module tb_line_clear_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    line_clear_sequencer_if bus();
    line_clear_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] lines;
        int         score;
        int         total;
        int         level;
    } vec_t;
    vec_t vecs [10];
    int m_score, m_total, m_level, m_prog, n_clean, n_merge;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.lock_req      = 1'b0;
        bus.clean_done    = 1'b0;
        bus.clean_lines   = '0;
        bus.spawn_ack     = 1'b0;
        bus.spawn_blocked = 1'b0;
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_merge_we"}, bus.merge_we, 0);
        chk({tag, "_clean_en"}, bus.clean_en, 0);
        chk({tag, "_spawn_req"}, bus.spawn_req, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_score"}, bus.score, 0);
        chk({tag, "_total"}, bus.total_lines, 0);
        chk({tag, "_level"}, bus.level, 0);
        chk({tag, "_game_over"}, bus.game_over, 0);
        chk({tag, "_err_timeout"}, bus.err_timeout, 0);
    endtask

    // Starts and ends on a negedge with the sequencer in IDLE.
    task automatic run_event(input logic [2:0] lines, input logic blocked);
        bus.lock_req = 1'b1;
        @(negedge clk);
        bus.lock_req = 1'b0;
        chk("merge_we_pulse", bus.merge_we, 1);
        chk("busy_merge", bus.busy, 1);
        @(negedge clk);
        chk("merge_we_single", bus.merge_we, 0);
        chk("clean_en_on", bus.clean_en, 1);
        bus.clean_done  = 1'b1;
        bus.clean_lines = lines;
        @(negedge clk);
        bus.clean_done  = 1'b0;
        bus.clean_lines = '0;
        chk("clean_en_off", bus.clean_en, 0);
        @(negedge clk);
        chk("spawn_req_on", bus.spawn_req, 1);
        @(negedge clk);
        chk("spawn_req_held", bus.spawn_req, 1);
        bus.spawn_ack     = 1'b1;
        bus.spawn_blocked = blocked;
        @(negedge clk);
        bus.spawn_ack     = 1'b0;
        bus.spawn_blocked = 1'b0;
        chk("spawn_req_drop", bus.spawn_req, 0);
        chk("busy_after", bus.busy, 0);
    endtask

    initial begin
        vecs[0] = '{3'd1, 40,    1,  0};
        vecs[1] = '{3'd4, 1240,  5,  0};
        vecs[2] = '{3'd4, 2440,  9,  0};
        vecs[3] = '{3'd2, 2540,  11, 1};
        vecs[4] = '{3'd3, 3140,  14, 1};
        vecs[5] = '{3'd0, 3140,  14, 1};
        vecs[6] = '{3'd7, 5540,  18, 1};
        vecs[7] = '{3'd4, 7940,  22, 2};
        vecs[8] = '{3'd4, 11540, 26, 2};
        vecs[9] = '{3'd1, 11660, 27, 2};
        idle_inputs();
        repeat (2) @(negedge clk);
        outs_zero("reset");
        rst = 1'b0;
        bus.clean_done  = 1'b1;
        bus.clean_lines = 3'd4;
        bus.spawn_ack   = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("stray_busy", bus.busy, 0);
        chk("stray_score", bus.score, 0);
        chk("stray_spawn_req", bus.spawn_req, 0);

        foreach (vecs[i]) begin
            run_event(vecs[i].lines, 1'b0);
            chk($sformatf("vec%0d_score", i), bus.score, vecs[i].score);
            chk($sformatf("vec%0d_total", i), bus.total_lines, vecs[i].total);
            chk($sformatf("vec%0d_level", i), bus.level, vecs[i].level);
        end

        // clearer never answers; a second lock during CLEAN must be dropped
        bus.lock_req = 1'b1;
        @(negedge clk);
        bus.lock_req = 1'b0;
        chk("to_merge_we", bus.merge_we, 1);
        n_clean = 0;
        n_merge = 0;
        for (int i = 0; i < 300; i++) begin
            bus.lock_req = (i == 10);
            @(negedge clk);
            n_clean += int'(bus.clean_en);
            n_merge += int'(bus.merge_we);
        end
        bus.lock_req = 1'b0;
        chk("to_clean_cycles", n_clean, 256);
        chk("to_extra_merge", n_merge, 0);
        chk("to_err_timeout", bus.err_timeout, 1);
        chk("to_spawn_req", bus.spawn_req, 1);
        chk("to_busy", bus.busy, 1);
        chk("to_score", bus.score, 11660);
        chk("to_total", bus.total_lines, 27);
        bus.spawn_ack = 1'b1;
        @(negedge clk);
        bus.spawn_ack = 1'b0;
        chk("to_spawn_drop", bus.spawn_req, 0);
        chk("to_idle", bus.busy, 0);

        m_score = 11660;
        m_total = 27;
        m_level = 2;
        m_prog  = 7;
        for (int i = 0; i < 90; i++) begin
            run_event(3'd4, 1'b0);
            m_score = m_score + 1200 * (m_level + 1);
            if (m_score > 999999) m_score = 999999;
            m_total += 4;
            m_prog  += 4;
            if (m_prog >= 10) begin
                m_prog -= 10;
                if (m_level < 15) m_level++;
            end
            chk($sformatf("sat%0d_score", i), bus.score, m_score);
            chk($sformatf("sat%0d_total", i), bus.total_lines, m_total);
            chk($sformatf("sat%0d_level", i), bus.level, m_level);
        end
        chk("sat_score_ceiling", bus.score, 999999);
        chk("sat_level_ceiling", bus.level, 15);
        chk("err_timeout_sticky", bus.err_timeout, 1);

        run_event(3'd1, 1'b1);
        chk("over_game_over", bus.game_over, 1);
        chk("over_score", bus.score, 999999);
        chk("over_total", bus.total_lines, m_total + 1);
        bus.lock_req = 1'b1;
        @(negedge clk);
        bus.lock_req = 1'b0;
        chk("over_no_merge", bus.merge_we, 0);
        chk("over_busy", bus.busy, 0);
        @(negedge clk);
        chk("over_no_clean", bus.clean_en, 0);
        chk("over_sticky", bus.game_over, 1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        outs_zero("reset2");
        bus.lock_req = 1'b1;
        @(negedge clk);
        bus.lock_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_clean_en", bus.clean_en, 1);
        rst = 1'b1;
        @(negedge clk);
        outs_zero("rst_mid_clean");
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_clean_en", bus.clean_en, 0);
        chk("post_rst_busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
